// File: rtl/mem_stall_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stall_bridge_if
//  Description : SRAM-like data bus (req / addr_ok / data_ok) between the
//                MEM-stage access bridge (master) and the bus converter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stall_bridge_if #(
   parameter int ADDR_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req,
      output data_wr,
      output data_size,
      output data_addr,
      output data_wdata,
      input  data_addr_ok,
      input  data_data_ok,
      input  data_rdata
   );

   modport slave (
      input  data_req,
      input  data_wr,
      input  data_size,
      input  data_addr,
      input  data_wdata,
      output data_addr_ok,
      output data_data_ok,
      output data_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_stall_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stall_bridge
//  Description : MEM-stage data-access bridge. Issues one bus access per
//                load/store, stalls the pipeline until it completes, drains
//                accesses of flushed instructions and holds load data.
//                Optional macro ALIGN_CHECK_EN adds adel/ades misalignment
//                outputs and suppresses misaligned accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stall_bridge #(
   parameter int ADDR_W = 32
) (
   input  wire                clk,
   input  wire                resetn,
   input  wire                mem_en,
   input  wire                mem_wr,
   input  wire [1:0]          mem_size,
   input  wire [ADDR_W-1:0]   mem_addr,
   input  wire [31:0]         mem_wdata,
   input  wire                flushM,
   output logic               stallreq_from_mem,
   output logic [31:0]        mem_rdata,
   output logic               mem_rdata_valid,
   mem_stall_bridge_if.master bus
`ifdef ALIGN_CHECK_EN
   ,
   output logic               adel,
   output logic               ades
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              issue_ok;

`ifdef ALIGN_CHECK_EN
   logic misaligned;

   // Halfwords need addr[0]==0, words need addr[1:0]==0; byte is always fine.
   always_comb begin
      misaligned = 1'b0;
      case (mem_size)
         2'b01:   misaligned = mem_addr[0];
         2'b10:   misaligned = |mem_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   assign issue_ok = ~misaligned;
   assign adel     = (state_q == S_IDLE) & mem_en & misaligned & ~mem_wr;
   assign ades     = (state_q == S_IDLE) & mem_en & misaligned &  mem_wr;
`else
   assign issue_ok = 1'b1;
`endif

   // Next-state, request capture and handshake outputs.
   always_comb begin
      state_d           = state_q;
      wr_d              = wr_q;
      size_d            = size_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      rdata_d           = rdata_q;
      stallreq_from_mem = 1'b0;
      mem_rdata_valid   = 1'b0;
      bus.data_req      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The stall must be raised in the issue cycle itself so the
            // hazard unit freezes the instruction before it leaves MEM.
            if (mem_en && !flushM && issue_ok) begin
               wr_d              = mem_wr;
               size_d            = mem_size;
               addr_d            = mem_addr;
               wdata_d           = mem_wdata;
               stallreq_from_mem = 1'b1;
               state_d           = S_REQ;
            end
         end
         S_REQ: begin
            stallreq_from_mem = 1'b1;
            bus.data_req      = 1'b1;
            if (bus.data_addr_ok) begin
               // Once the address is accepted the access can't be withdrawn.
               state_d = flushM ? S_DRAIN : S_WAIT;
            end else if (flushM) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            stallreq_from_mem = 1'b1;
            if (bus.data_data_ok) begin
               // A flush coinciding with the response: the access is already
               // finished, so nothing is left to drain; just discard it.
               if (flushM) begin
                  state_d = S_IDLE;
               end else begin
                  if (!wr_q) begin
                     rdata_d = bus.data_rdata;
                  end
                  state_d = S_DONE;
               end
            end else if (flushM) begin
               state_d = S_DRAIN;
            end
         end
         S_DONE: begin
            mem_rdata_valid = 1'b1;
            state_d         = S_IDLE;
         end
         S_DRAIN: begin
            stallreq_from_mem = 1'b1;
            if (bus.data_data_ok) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Bus fields come straight from the captured request, so they stay stable
   // for the whole time data_req is high.
   assign bus.data_wr    = wr_q;
   assign bus.data_size  = size_q;
   assign bus.data_addr  = addr_q;
   assign bus.data_wdata = wdata_q;
   assign mem_rdata      = rdata_q;

   // State and request registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stall_bridge
//  Description : Self-checking bench for mem_stall_bridge. Each access is
//                described at transaction level (address-phase length,
//                data-phase length, optional flush cycle); the expected
//                per-cycle stall/request/valid pattern is derived from that
//                timeline. Honours ALIGN_CHECK_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stall_bridge;

   logic        clk;
   logic        resetn;
   logic        mem_en;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        flushM;
   logic        stallreq_from_mem;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid;
`ifdef ALIGN_CHECK_EN
   logic        adel;
   logic        ades;
`endif

   mem_stall_bridge_if #(.ADDR_W(32)) bus ();

   mem_stall_bridge #(.ADDR_W(32)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .mem_en            (mem_en),
      .mem_wr            (mem_wr),
      .mem_size          (mem_size),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .flushM            (flushM),
      .stallreq_from_mem (stallreq_from_mem),
      .mem_rdata         (mem_rdata),
      .mem_rdata_valid   (mem_rdata_valid),
      .bus               (bus)
`ifdef ALIGN_CHECK_EN
      ,
      .adel              (adel),
      .ades              (ades)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access: r = cycles data_req is up before addr_ok (addr_ok in the
   // r-th request cycle), w = cycles from address acceptance to data_ok,
   // f = cycle (0 = issue cycle) at which flushM pulses, -1 for none.
   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          gap;
      int          r;
      int          w;
      int          f;
      int          exp_stall;
      logic        exp_valid;
      logic [31:0] exp_rdata;
   } vec_t;

   int          n_vec;
   int          n_err;
   logic [31:0] model_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic idle_cycle();
      mem_en            = 1'b0;
      flushM            = 1'b0;
      mem_wr            = 1'($urandom_range(0, 1));
      mem_size          = 2'($urandom_range(0, 2));
      mem_addr          = $urandom;
      mem_wdata         = $urandom;
      bus.data_addr_ok  = 1'b0;
      bus.data_data_ok  = ($urandom_range(0, 3) == 0);
      bus.data_rdata    = $urandom;
      #4;
      chk("idle_stall", {31'h0, stallreq_from_mem}, 32'h0);
      chk("idle_req",   {31'h0, bus.data_req},      32'h0);
      chk("idle_valid", {31'h0, mem_rdata_valid},   32'h0);
      chk("idle_rdata", mem_rdata, model_rdata);
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v, input bit directed);
      bit flushed, dropped, live, e_stall, e_req, e_valid;
      int len, st_cnt, vl_cnt, d_cyc;
      for (int g = 0; g < v.gap; g++) idle_cycle();
      flushed = (v.f >= 0);
      dropped = flushed && (v.f < v.r);
      d_cyc   = v.r + v.w;
      len     = dropped ? v.f + 2 : d_cyc + 2;
      st_cnt  = 0;
      vl_cnt  = 0;
      for (int k = 0; k < len; k++) begin
         live = flushed ? (k <= v.f) : 1'b1;
         mem_en    = live;
         mem_wr    = live ? v.wr    : 1'($urandom_range(0, 1));
         mem_size  = live ? v.size  : 2'($urandom_range(0, 2));
         mem_addr  = live ? v.addr  : $urandom;
         mem_wdata = live ? v.wdata : $urandom;
         flushM    = flushed && (k == v.f);
         bus.data_addr_ok = !dropped && (k == v.r);
         bus.data_data_ok = !dropped && (k == d_cyc);
         bus.data_rdata   = (k == d_cyc) ? v.rdata : $urandom;

         if (dropped) e_stall = (v.f > 0) && (k <= v.f);
         else         e_stall = (k <= d_cyc);
         e_req   = (k >= 1) && (k <= v.r) && (!dropped || k <= v.f);
         e_valid = !flushed && (k == d_cyc + 1);
         if (e_valid && !v.wr) model_rdata = v.rdata;

         #4;
         chk("stall", {31'h0, stallreq_from_mem}, {31'h0, e_stall});
         chk("req",   {31'h0, bus.data_req},      {31'h0, e_req});
         chk("valid", {31'h0, mem_rdata_valid},   {31'h0, e_valid});
         chk("rdata", mem_rdata, model_rdata);
         if (e_req) begin
            chk("bus_addr",  bus.data_addr,  v.addr);
            chk("bus_wdata", bus.data_wdata, v.wdata);
            chk("bus_wr",    {31'h0, bus.data_wr},   {31'h0, v.wr});
            chk("bus_size",  {30'h0, bus.data_size}, {30'h0, v.size});
         end
         st_cnt += int'(stallreq_from_mem);
         vl_cnt += int'(mem_rdata_valid);
         @(posedge clk);
         #1;
      end
      if (directed) begin
         chk("tbl_stall_cycles", st_cnt, v.exp_stall);
         chk("tbl_valid_pulses", vl_cnt, {31'h0, v.exp_valid});
         chk("tbl_rdata",        mem_rdata, v.exp_rdata);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int gap, input int r, input int w, input int f,
                               input int es, input logic ev, input logic [31:0] er);
      vec_t v;
      v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.gap = gap; v.r = r; v.w = w; v.f = f;
      v.exp_stall = es; v.exp_valid = ev; v.exp_rdata = er;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      vec_t v;
      n_vec = 0;
      n_err = 0;
      model_rdata = 32'h0;

      //          wr    size   addr          wdata         rdata       gap r  w  f   stall valid rdata-after
      tbl[0]  = mk(1'b0, 2'b10, 32'h00000010, 32'h0,        32'hDEADBEEF, 1, 1, 1, -1, 3, 1'b1, 32'hDEADBEEF);
      tbl[1]  = mk(1'b1, 2'b10, 32'h00000020, 32'h12345678, 32'h0BADF00D, 1, 4, 1, -1, 6, 1'b1, 32'hDEADBEEF);
      tbl[2]  = mk(1'b0, 2'b10, 32'h00000030, 32'h0,        32'hAAAA5555, 1, 1, 3,  2, 5, 1'b0, 32'hDEADBEEF);
      tbl[3]  = mk(1'b0, 2'b10, 32'h00000040, 32'h0,        32'h99999999, 1, 3, 1,  2, 3, 1'b0, 32'hDEADBEEF);
      tbl[4]  = mk(1'b0, 2'b10, 32'h00000050, 32'h0,        32'h11111111, 2, 1, 1, -1, 3, 1'b1, 32'h11111111);
      tbl[5]  = mk(1'b0, 2'b10, 32'h00000054, 32'h0,        32'h22222222, 0, 2, 2, -1, 5, 1'b1, 32'h22222222);
      tbl[6]  = mk(1'b0, 2'b01, 32'h00000062, 32'h0,        32'h0000BEEF, 0, 1, 4,  0, 0, 1'b0, 32'h22222222);
      tbl[7]  = mk(1'b0, 2'b00, 32'h00000063, 32'h0,        32'h000000A5, 1, 2, 2,  2, 5, 1'b0, 32'h22222222);
      tbl[8]  = mk(1'b1, 2'b00, 32'h00000071, 32'h00AB0000, 32'h77777777, 1, 1, 2,  3, 4, 1'b0, 32'h22222222);
      tbl[9]  = mk(1'b1, 2'b01, 32'h00000076, 32'h55AA0000, 32'h66666666, 1, 2, 3, -1, 6, 1'b1, 32'h22222222);
      tbl[10] = mk(1'b0, 2'b10, 32'h00000080, 32'h0,        32'hCAFEF00D, 0, 3, 2, -1, 6, 1'b1, 32'hCAFEF00D);

      // Reset state
      resetn = 1'b0;
      mem_en = 1'b0; mem_wr = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
      flushM = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      #2;
      chk("rst_stall", {31'h0, stallreq_from_mem}, 32'h0);
      chk("rst_req",   {31'h0, bus.data_req},      32'h0);
      chk("rst_valid", {31'h0, mem_rdata_valid},   32'h0);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_addr",  bus.data_addr, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;

      // Directed table
      for (int i = 0; i < 11; i++) run_txn(tbl[i], 1'b1);

`ifdef ALIGN_CHECK_EN
      // Misaligned word load and half store: no bus access, no stall.
      idle_cycle();
      mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h00000002;
      #4;
      chk("adel",       {31'h0, adel},              32'h1);
      chk("adel_ades",  {31'h0, ades},              32'h0);
      chk("adel_stall", {31'h0, stallreq_from_mem}, 32'h0);
      @(posedge clk); #1;
      chk("adel_req",   {31'h0, bus.data_req},      32'h0);
      mem_wr = 1'b1; mem_size = 2'b01; mem_addr = 32'h00000003;
      #3;
      chk("ades",       {31'h0, ades},              32'h1);
      chk("ades_adel",  {31'h0, adel},              32'h0);
      chk("ades_stall", {31'h0, stallreq_from_mem}, 32'h0);
      @(posedge clk); #1;
      chk("ades_req",   {31'h0, bus.data_req},      32'h0);
      mem_en = 1'b0;
      idle_cycle();
`endif

      // Randomized accesses
      for (int i = 0; i < 200; i++) begin
         v.wr    = 1'($urandom_range(0, 1));
         v.size  = 2'($urandom_range(0, 2));
         v.addr  = $urandom;
`ifdef ALIGN_CHECK_EN
         if (v.size == 2'b01) v.addr[0]   = 1'b0;
         if (v.size == 2'b10) v.addr[1:0] = 2'b00;
`endif
         v.wdata = $urandom;
         v.rdata = $urandom;
         v.gap   = $urandom_range(0, 2);
         v.r     = $urandom_range(1, 4);
         v.w     = $urandom_range(1, 4);
         v.f     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, v.r + v.w)) : -1;
         v.exp_stall = 0; v.exp_valid = 1'b0; v.exp_rdata = 32'h0;
         run_txn(v, 1'b0);
      end

      // Reset in the middle of an access
      mem_en = 1'b1; mem_wr = 1'b0; mem_size = 2'b10; mem_addr = 32'h00000100; flushM = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      @(posedge clk); #1;
      chk("mid_req_before", {31'h0, bus.data_req}, 32'h1);
      mem_en = 1'b0;
      resetn = 1'b0;
      #1;
      chk("mid_rst_req",   {31'h0, bus.data_req},      32'h0);
      chk("mid_rst_stall", {31'h0, stallreq_from_mem}, 32'h0);
      chk("mid_rst_rdata", mem_rdata, 32'h0);
      model_rdata = 32'h0;
      @(posedge clk); #1;
      resetn = 1'b1;
      run_txn(mk(1'b0, 2'b10, 32'h00000200, 32'h0, 32'h3C3C3C3C, 1, 2, 1, -1, 4, 1'b1, 32'h3C3C3C3C), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
